// File: rtl/bp_be_fma_wb_buffer_if.sv
// Port bundle for the FMA/IMUL writeback buffer: issue and credit, pipe results,
// and the FP and INT writeback handshakes.
interface bp_be_fma_wb_buffer_if #(
  parameter int data_width_p     = 66,
  parameter int reg_addr_width_p = 5
);
  logic                        fma_issue_v_i;
  logic                        imul_issue_v_i;
  logic [reg_addr_width_p-1:0] issue_rd_i;
  logic                        fma_ready_o;
  logic                        imul_ready_o;
  logic                        flush_i;
  logic                        fma_v_i;
  logic [data_width_p-1:0]     fma_data_i;
  logic [4:0]                  fma_fflags_i;
  logic                        imul_v_i;
  logic [63:0]                 imul_data_i;
  logic                        fp_wb_v_o;
  logic [reg_addr_width_p-1:0] fp_wb_rd_o;
  logic [data_width_p-1:0]     fp_wb_data_o;
  logic                        fp_wb_yumi_i;
  logic                        int_wb_v_o;
  logic [reg_addr_width_p-1:0] int_wb_rd_o;
  logic [63:0]                 int_wb_data_o;
  logic                        int_wb_yumi_i;
  logic [4:0]                  fflags_o;
  logic                        fflags_clear_i;

  modport slave (
    input  fma_issue_v_i, imul_issue_v_i, issue_rd_i, flush_i,
    input  fma_v_i, fma_data_i, fma_fflags_i, imul_v_i, imul_data_i,
    input  fp_wb_yumi_i, int_wb_yumi_i, fflags_clear_i,
    output fma_ready_o, imul_ready_o,
    output fp_wb_v_o, fp_wb_rd_o, fp_wb_data_o,
    output int_wb_v_o, int_wb_rd_o, int_wb_data_o, fflags_o
  );

  modport master (
    output fma_issue_v_i, imul_issue_v_i, issue_rd_i, flush_i,
    output fma_v_i, fma_data_i, fma_fflags_i, imul_v_i, imul_data_i,
    output fp_wb_yumi_i, int_wb_yumi_i, fflags_clear_i,
    input  fma_ready_o, imul_ready_o,
    input  fp_wb_v_o, fp_wb_rd_o, fp_wb_data_o,
    input  int_wb_v_o, int_wb_rd_o, int_wb_data_o, fflags_o
  );
endinterface

// File: rtl/bp_be_fma_wb_buffer.sv
// FMA/IMUL writeback buffer: tag chains, credit-gated FIFOs, sticky FP flags.
// Define BP_BE_FMA_WB_BYPASS_EN to show arrivals into an empty FIFO in the same cycle.
module bp_be_fma_wb_lane #(
  parameter int latency_p       = 5,
  parameter int els_p           = 8,
  parameter int rd_width_p      = 5,
  parameter int payload_width_p = 71
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       issue_v_i,
  input  logic [rd_width_p-1:0]      issue_rd_i,
  input  logic                       flush_i,
  input  logic                       res_v_i,
  input  logic [payload_width_p-1:0] res_data_i,
  input  logic                       yumi_i,
  output logic                       ready_o,
  output logic                       wb_v_o,
  output logic [rd_width_p-1:0]      wb_rd_o,
  output logic [payload_width_p-1:0] wb_data_o
);
  localparam int ptr_w   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w   = $clog2(els_p + 1);
  localparam int entry_w = rd_width_p + payload_width_p;
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);

  // occ marks an issued op (it holds a credit); live is cleared by flush
  logic [latency_p-1:0]  occ_reg, live_reg;
  logic [rd_width_p-1:0] rd_reg [latency_p];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      occ_reg  <= '0;
      live_reg <= '0;
      for (int i = 0; i < latency_p; i++) rd_reg[i] <= '0;
    end else begin
      occ_reg  <= {occ_reg[latency_p-2:0], issue_v_i};
      live_reg <= {live_reg[latency_p-2:0], issue_v_i} & {latency_p{~flush_i}};
      for (int i = latency_p - 1; i > 0; i--) rd_reg[i] <= rd_reg[i-1];
      rd_reg[0] <= issue_rd_i;
    end
  end

  logic head_live, push, poison_exit;
  assign head_live   = live_reg[latency_p-1];
  assign push        = head_live & res_v_i;
  assign poison_exit = occ_reg[latency_p-1] & ~head_live;

  logic [entry_w-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr_reg, wptr_reg;
  logic [cnt_w-1:0]   cnt_reg, credits_reg;
  logic               empty, wr_en, rd_en;
  logic [entry_w-1:0] head_entry, arrival_entry;

  assign empty         = (cnt_reg == '0);
  assign arrival_entry = {rd_reg[latency_p-1], res_data_i};

`ifdef BP_BE_FMA_WB_BYPASS_EN
  // an arrival consumed in its own cycle never touches storage
  assign wr_en      = push & ~(empty & yumi_i);
  assign rd_en      = yumi_i & ~empty;
  assign wb_v_o     = ~empty | push;
  assign head_entry = empty ? arrival_entry : mem[rptr_reg];
`else
  assign wr_en      = push;
  assign rd_en      = yumi_i;
  assign wb_v_o     = ~empty;
  assign head_entry = mem[rptr_reg];
`endif

  assign {wb_rd_o, wb_data_o} = head_entry;
  assign ready_o              = (credits_reg != '0);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr_reg] <= arrival_entry;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rptr_reg    <= '0;
      wptr_reg    <= '0;
      cnt_reg     <= '0;
      credits_reg <= cnt_w'(els_p);
    end else begin
      if (wr_en) wptr_reg <= (wptr_reg == last_ptr) ? '0 : wptr_reg + ptr_w'(1);
      if (rd_en) rptr_reg <= (rptr_reg == last_ptr) ? '0 : rptr_reg + ptr_w'(1);
      cnt_reg     <= cnt_reg + cnt_w'(wr_en) - cnt_w'(rd_en);
      // a poisoned head frees the slot it reserved at issue
      credits_reg <= credits_reg + cnt_w'(yumi_i) + cnt_w'(poison_exit) - cnt_w'(issue_v_i);
    end
  end

  a_issue_credit: assert property (@(posedge clk_i) disable iff (!reset_i) issue_v_i |-> ready_o);
  a_head_match:   assert property (@(posedge clk_i) disable iff (!reset_i) head_live |-> res_v_i);
  a_yumi_legal:   assert property (@(posedge clk_i) disable iff (!reset_i) yumi_i |-> wb_v_o);
endmodule

module bp_be_fma_wb_buffer #(
  parameter int data_width_p     = 66,
  parameter int reg_addr_width_p = 5,
  parameter int fma_latency_p    = 5,
  parameter int imul_latency_p   = 4,
  parameter int els_p            = 8
) (
  input logic                   clk_i,
  input logic                   reset_i,
  bp_be_fma_wb_buffer_if.slave  io
);
  localparam int fp_pw = data_width_p + 5;

  logic [fp_pw-1:0] fp_payload;
  logic [4:0]       fflags_reg;

  bp_be_fma_wb_lane #(
    .latency_p(fma_latency_p), .els_p(els_p),
    .rd_width_p(reg_addr_width_p), .payload_width_p(fp_pw)
  ) fp_lane (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_v_i(io.fma_issue_v_i), .issue_rd_i(io.issue_rd_i), .flush_i(io.flush_i),
    .res_v_i(io.fma_v_i), .res_data_i({io.fma_data_i, io.fma_fflags_i}),
    .yumi_i(io.fp_wb_yumi_i), .ready_o(io.fma_ready_o),
    .wb_v_o(io.fp_wb_v_o), .wb_rd_o(io.fp_wb_rd_o), .wb_data_o(fp_payload)
  );

  bp_be_fma_wb_lane #(
    .latency_p(imul_latency_p), .els_p(els_p),
    .rd_width_p(reg_addr_width_p), .payload_width_p(64)
  ) int_lane (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_v_i(io.imul_issue_v_i), .issue_rd_i(io.issue_rd_i), .flush_i(io.flush_i),
    .res_v_i(io.imul_v_i), .res_data_i(io.imul_data_i),
    .yumi_i(io.int_wb_yumi_i), .ready_o(io.imul_ready_o),
    .wb_v_o(io.int_wb_v_o), .wb_rd_o(io.int_wb_rd_o), .wb_data_o(io.int_wb_data_o)
  );

  assign io.fp_wb_data_o = fp_payload[fp_pw-1:5];

  // a pop in the clearing cycle still contributes its flags
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fflags_reg <= '0;
    end else if (io.fflags_clear_i || io.fp_wb_yumi_i) begin
      fflags_reg <= (io.fflags_clear_i ? 5'd0 : fflags_reg)
                  | (io.fp_wb_yumi_i ? fp_payload[4:0] : 5'd0);
    end
  end

  assign io.fflags_o = fflags_reg;

  a_issue_excl: assert property (@(posedge clk_i) disable iff (!reset_i)
                                 !(io.fma_issue_v_i && io.imul_issue_v_i));
endmodule
